led_matrix_column_scanner: RTL

- Time-multiplexes the 5x7 LED matrix on the CPLD kit, downstream of the irrigation image decoder.
- Consumes the decoder's three Y-symmetric image columns and snapshots them once per frame to prevent tearing.
- Drives one physical column at a time, with row data and a ghosting blank interval per column slot.
- Emits a frame-complete pulse for upstream sequencing.

---
 rtl/led_matrix_column_scanner_pkg.sv | 50 +++++
 rtl/led_matrix_column_scanner_if.sv | 24 ++
 rtl/led_matrix_column_scanner_slot_timer.sv | 42 ++++
 rtl/led_matrix_column_scanner.sv | 120 ++++++++++++
 4 files changed

// File: rtl/led_matrix_column_scanner_pkg.sv
// Shared types for the 5x7 LED matrix scanner: scan states, geometry and the column-to-image map.
// The decoder delivers three Y-symmetric columns, so physical columns 0/4 and 1/3 share image data.
package matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    IMG_COL0 = 2'd0,
    IMG_COL1 = 2'd1,
    IMG_COL2 = 2'd2
  } img_sel_e;

  typedef logic [NUM_ROWS-1:0] row_t;
  typedef logic [NUM_COLS-1:0] col_mask_t;
  typedef logic [2:0]          col_idx_t;

  typedef struct packed {
    row_t col_2;
    row_t col_1;
    row_t col_0;
  } image_t;

  function automatic img_sel_e col_to_img(input col_idx_t idx);
    img_sel_e sel;
    case (idx)
      3'd0, 3'd4: sel = IMG_COL2;
      3'd1, 3'd3: sel = IMG_COL1;
      default:    sel = IMG_COL0;
    endcase
    return sel;
  endfunction

  function automatic row_t pick_row(input image_t img, input col_idx_t idx);
    row_t r;
    case (col_to_img(idx))
      IMG_COL2: r = img.col_2;
      IMG_COL1: r = img.col_1;
      default:  r = img.col_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_matrix_column_scanner_if.sv
// Image-in / matrix-out bundle between the image decoder, the scanner and the LED pins.
// The scanner side uses the slave modport; the decoder/pin side (or a bench) uses master.
interface led_matrix_column_scanner_if;
  import matrix_pkg::*;

  logic      enable;
  row_t      col_2;
  row_t      col_1;
  row_t      col_0;
  col_mask_t col_sel;
  row_t      row_out;
  logic      frame_done;

  modport master (
    output enable, col_2, col_1, col_0,
    input  col_sel, row_out, frame_done
  );

  modport slave (
    input  enable, col_2, col_1, col_0,
    output col_sel, row_out, frame_done
  );

endinterface

// File: rtl/led_matrix_column_scanner_slot_timer.sv
// Per-column slot counter with strobes on the last blank clock and the last slot clock.
// Strobes are combinational from the counter; clr has priority over run.
module matrix_slot_timer #(
  parameter int DIVIDER      = 10000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blank_end = (cnt_q == BLANK_LAST);
  assign slot_end  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/led_matrix_column_scanner.sv
// Column-multiplexed driver for the 5x7 LED matrix with per-frame image snapshot and blanking.
// Pin outputs and frame_done are registered one clock behind the scan state.
module led_matrix_column_scanner
  import matrix_pkg::*;
#(
  parameter int DIVIDER        = 10000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  led_matrix_column_scanner_if.slave    scan
);

  localparam col_mask_t COL_OFF  = COL_ACTIVE_LOW ? {NUM_COLS{1'b1}} : '0;
  localparam row_t      ROW_OFF  = ROW_ACTIVE_LOW ? {NUM_ROWS{1'b1}} : '0;
  localparam col_idx_t  LAST_COL = col_idx_t'(NUM_COLS - 1);

  scan_state_e state_q, state_d;
  col_idx_t    idx_q, idx_d;
  image_t      shadow_q, shadow_d;
  col_mask_t   col_sel_q, col_sel_d;
  row_t        row_out_q, row_out_d;
  logic        frame_done_q, frame_done_d;

  logic blank_end;
  logic slot_end;
  logic slot_done;
  logic wrap;
  logic timer_clr;

  assign slot_done = (state_q == DRIVE) && slot_end;
  assign wrap      = slot_done && (idx_q == LAST_COL);
  assign timer_clr = !scan.enable || (state_q == IDLE) || slot_done;

  matrix_slot_timer #(
    .DIVIDER      (DIVIDER),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (timer_clr),
    .run       (state_q != IDLE),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      col_sel_q    <= COL_OFF;
      row_out_q    <= ROW_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      col_sel_q    <= col_sel_d;
      row_out_q    <= row_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // The shadow image only changes at frame boundaries so a frame never mixes two images.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (!scan.enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = '0;
          shadow_d = {scan.col_2, scan.col_1, scan.col_0};
        end
        BLANK: begin
          if (blank_end) begin
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (slot_end) begin
            state_d = BLANK;
            if (idx_q == LAST_COL) begin
              idx_d    = '0;
              shadow_d = {scan.col_2, scan.col_1, scan.col_0};
            end else begin
              idx_d = idx_q + col_idx_t'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    col_sel_d    = COL_OFF;
    row_out_d    = ROW_OFF;
    frame_done_d = scan.enable && wrap;
    if (state_q == DRIVE) begin
      col_sel_d = COL_OFF ^ (col_mask_t'(1) << idx_q);
      row_out_d = ROW_OFF ^ pick_row(shadow_q, idx_q);
    end
  end

  assign scan.col_sel    = col_sel_q;
  assign scan.row_out    = row_out_q;
  assign scan.frame_done = frame_done_q;

endmodule
